// File: rtl/hazard_stall_unit_if.sv
// Hazard-unit bundle between the pipeline (master) and hazard_stall_unit (slave).
// Optional HAZARD_STATS_EN adds the 16-bit stall_cycles observation signal.
interface hazard_stall_unit_if #(
  parameter int REG_W = 6
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             id_branch_taken;
  logic             id_reads_hilo;
  logic             id_md_start;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             stall_pc;
  logic             stall_ifid;
  logic             flush_idex;
  logic             flush_ifid;
  logic             md_busy;
`ifdef HAZARD_STATS_EN
  logic [15:0]      stall_cycles;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
           id_branch_taken, id_reads_hilo, id_md_start, ex_rd, ex_reg_write,
           ex_mem_read,
    input  stall_pc, stall_ifid, flush_idex, flush_ifid, md_busy
`ifdef HAZARD_STATS_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
           id_branch_taken, id_reads_hilo, id_md_start, ex_rd, ex_reg_write,
           ex_mem_read,
    output stall_pc, stall_ifid, flush_idex, flush_ifid, md_busy
`ifdef HAZARD_STATS_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use, branch-operand and HI/LO stalls plus taken-branch flush.
// Define HAZARD_STATS_EN to add a saturating 16-bit stall-cycle counter (stall_cycles).
module hazard_stall_unit #(
  parameter int REG_W  = 6,
  parameter int MD_LAT = 4
) (
  input logic                clk,
  input logic                rst,
  hazard_stall_unit_if.slave hz
);

  typedef enum logic {RUN, HOLD1} state_e;

  localparam int CNT_W = $clog2(MD_LAT + 1);
  localparam logic [REG_W-1:0] ZERO_TAG = '0;
  localparam logic [CNT_W-1:0] MD_LOAD  = CNT_W'(MD_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             m_rs, m_rt, tag_hit;
  logic             load_use, branch_alu, branch_load, hilo;
  logic             md_busy, stall;

  // Register 0 is hardwired, so a zero destination tag never creates a dependency.
  assign m_rs = hz.id_valid & hz.id_uses_rs & hz.ex_reg_write &
                (hz.ex_rd != ZERO_TAG) & (hz.ex_rd == hz.id_rs);
  assign m_rt = hz.id_valid & hz.id_uses_rt & hz.ex_reg_write &
                (hz.ex_rd != ZERO_TAG) & (hz.ex_rd == hz.id_rt);
  assign tag_hit = m_rs | m_rt;

  assign md_busy     = (md_cnt_q != '0);
  assign load_use    = hz.ex_mem_read & tag_hit;
  assign branch_alu  = hz.id_is_branch & ~hz.ex_mem_read & tag_hit;
  assign branch_load = hz.id_is_branch & hz.ex_mem_read & tag_hit;
  assign hilo        = hz.id_valid & (hz.id_reads_hilo | hz.id_md_start) & md_busy;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        stall = load_use | branch_alu | branch_load | hilo;
        if (branch_load) state_d = HOLD1;
      end
      HOLD1: begin
        stall   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // A MULT/DIV only issues when ID is not held, which also keeps it from overlapping a busy unit.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hz.id_valid & hz.id_md_start & ~stall) md_cnt_d = MD_LOAD;
    else if (md_busy)                          md_cnt_d = md_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign hz.stall_pc   = stall;
  assign hz.stall_ifid = stall;
  assign hz.flush_idex = stall;
  assign hz.flush_ifid = hz.id_branch_taken & ~stall;
  assign hz.md_busy    = md_busy;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign hz.stall_cycles = stall_cnt_q;
`endif

endmodule
